// File: rtl/wb_port_arbiter_pkg.sv
// Shared write-back arbitration constants: mux select encodings, source count,
// and the base-order priority picker used by the grant logic.
package wb_port_arbiter_pkg;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_LOAD = 2'b01;
    localparam logic [1:0] WB_SEL_MD   = 2'b10;
    localparam int         WB_NSRC     = 3;

    // Request bit positions: [0] ALU, [1] LOAD, [2] MULDIV. Base order LOAD > MULDIV > ALU.
    function automatic logic [WB_NSRC-1:0] prio_pick(input logic [WB_NSRC-1:0] req);
        logic [WB_NSRC-1:0] gnt;
        gnt = '0;
        if (req[1])      gnt[1] = 1'b1;
        else if (req[2]) gnt[2] = 1'b1;
        else if (req[0]) gnt[0] = 1'b1;
        return gnt;
    endfunction

endpackage

// File: rtl/wb_age_counter.sv
// Per-source starvation age: counts consecutive blocked cycles, saturating at LIMIT.
// Urgent once the count reaches LIMIT; cleared on grant, idle or flush.
module wb_age_counter #(
    parameter int LIMIT = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_valid,
    input  logic       i_ready,
    input  logic       i_flush,
    output logic [2:0] o_count,
    output logic       o_urgent
);

    localparam logic [2:0] LIM = LIMIT[2:0];

    logic [2:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_flush || i_ready || !i_valid) begin
            r_count <= '0;
        end else if (r_count != LIM) begin
            r_count <= r_count + 3'd1;
        end
    end

    assign o_count  = r_count;
    assign o_urgent = (r_count == LIM);

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter for ALU / LOAD / MULDIV: combinational grant,
// registered write one cycle after the grant; urgent (starved) sources jump the queue.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_flush,
    input  logic            i_alu_valid,
    input  logic [4:0]      i_alu_rd,
    input  logic [XLEN-1:0] i_alu_data,
    output logic            o_alu_ready,
    input  logic            i_ld_valid,
    input  logic [4:0]      i_ld_rd,
    input  logic [XLEN-1:0] i_ld_data,
    output logic            o_ld_ready,
    input  logic            i_md_valid,
    input  logic [4:0]      i_md_rd,
    input  logic [XLEN-1:0] i_md_data,
    output logic            o_md_ready,
    output logic [1:0]      o_wb_sel,
    output logic            o_rf_we,
    output logic [4:0]      o_rf_rd,
    output logic [XLEN-1:0] o_rf_wdata,
    output logic            o_wb_busy
);

    logic [WB_NSRC-1:0] w_valid;
    logic [WB_NSRC-1:0] w_urgent;
    logic [WB_NSRC-1:0] w_req;
    logic [WB_NSRC-1:0] w_gnt;
    logic [2:0]         w_age_alu;
    logic [2:0]         w_age_ld;
    logic [2:0]         w_age_md;
    logic [1:0]         w_sel_nxt;
    logic [4:0]         w_rd_nxt;
    logic [XLEN-1:0]    w_data_nxt;

    logic               r_we;
    logic [1:0]         r_sel;
    logic [4:0]         r_rd;
    logic [XLEN-1:0]    r_wdata;

    assign w_valid = {i_md_valid, i_ld_valid, i_alu_valid};

    wb_age_counter #(.LIMIT(STARVE_LIMIT)) u_age_alu (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_alu_valid), .i_ready(o_alu_ready),
        .i_flush(i_flush), .o_count(w_age_alu), .o_urgent(w_urgent[0])
    );
    wb_age_counter #(.LIMIT(STARVE_LIMIT)) u_age_ld (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_ld_valid), .i_ready(o_ld_ready),
        .i_flush(i_flush), .o_count(w_age_ld), .o_urgent(w_urgent[1])
    );
    wb_age_counter #(.LIMIT(STARVE_LIMIT)) u_age_md (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_md_valid), .i_ready(o_md_ready),
        .i_flush(i_flush), .o_count(w_age_md), .o_urgent(w_urgent[2])
    );

    // Urgency is masked with valid: a stale saturated count must not win an empty slot.
    assign w_req = (|(w_urgent & w_valid)) ? (w_urgent & w_valid) : w_valid;
    assign w_gnt = (i_rst || i_flush) ? '0 : prio_pick(w_req);

    assign o_alu_ready = w_gnt[0];
    assign o_ld_ready  = w_gnt[1];
    assign o_md_ready  = w_gnt[2];
    assign o_wb_busy   = (|w_valid) && !(|w_gnt);

    always_comb begin
        w_sel_nxt  = WB_SEL_ALU;
        w_rd_nxt   = i_alu_rd;
        w_data_nxt = i_alu_data;
        if (w_gnt[1]) begin
            w_sel_nxt  = WB_SEL_LOAD;
            w_rd_nxt   = i_ld_rd;
            w_data_nxt = i_ld_data;
        end else if (w_gnt[2]) begin
            w_sel_nxt  = WB_SEL_MD;
            w_rd_nxt   = i_md_rd;
            w_data_nxt = i_md_data;
        end
    end

    // x0 writes still update sel/rd/data so the mux path stays consistent; only the strobe is suppressed.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_we    <= 1'b0;
            r_sel   <= WB_SEL_ALU;
            r_rd    <= '0;
            r_wdata <= '0;
        end else if (|w_gnt) begin
            r_we    <= (w_rd_nxt != 5'd0);
            r_sel   <= w_sel_nxt;
            r_rd    <= w_rd_nxt;
            r_wdata <= w_data_nxt;
        end else begin
            r_we    <= 1'b0;
        end
    end

    assign o_wb_sel   = r_sel;
    assign o_rf_we    = r_we;
    assign o_rf_rd    = r_rd;
    assign o_rf_wdata = r_wdata;

endmodule
